pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 100 ++++++++++
 tb/tb_pc_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// ----------------------------------------------------------------------------
// pc_unit -- program counter with a BOOT / RUN / HALTED control FSM.
//
// Ports
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   stall          in   1   hold pc while running
//   branch_taken   in   1   take pc_plus4 + (branch_offset << 2)
//   branch_offset  in  32   sign-extended word offset
//   jump           in   1   take {pc_plus4[31:28], jump_addr, 2'b00}
//   jump_addr      in  26   word-address field of the jump
//   halt           in   1   enter HALTED (dominates everything while running)
//   resume         in   1   leave HALTED for RUN
//   pc             out 32   current fetch address (registered)
//   pc_plus4       out 32   pc + 4, combinational
//   pc_valid       out  1   pc is a valid fetch address this cycle (RUN only)
//   halted         out  1   block is in HALTED
// ----------------------------------------------------------------------------
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_addr,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        pc_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc,    w_pc_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_tgt;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_seq_or_br;
    logic [31:0] w_flow_pc;

    // Offset shift drops the top two bits; the add wraps at 32 bits.
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_tgt    = w_pc_plus4 + {branch_offset[29:0], 2'b00};
    assign w_jmp_tgt   = {w_pc_plus4[31:28], jump_addr, 2'b00};

    // Two-level select: branch first, then jump overrides it.
    assign w_seq_or_br = branch_taken ? w_br_tgt  : w_pc_plus4;
    assign w_flow_pc   = jump         ? w_jmp_tgt : w_seq_or_br;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (halt)
                    w_state_nxt = HALTED;
                else if (!stall)
                    w_pc_nxt = w_flow_pc;
            end
            HALTED: begin
                // halt held high keeps the block parked even with resume.
                if (resume && !halt)
                    w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign pc_valid = (r_state == RUN);
    assign halted   = (r_state == HALTED);

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_addr;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        halted;

    int checks = 0;
    int errors = 0;

    pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_addr     (jump_addr),
        .halt          (halt),
        .resume        (resume),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .pc_valid      (pc_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [31:0] e_pc, input logic e_vld, input logic e_hlt);
        chk({tag, ".pc"},       pc,              e_pc);
        chk({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, e_vld});
        chk({tag, ".halted"},   {31'd0, halted},   {31'd0, e_hlt});
    endtask

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; branch_taken = 0; branch_offset = 0;
        jump = 0; jump_addr = 0; halt = 0; resume = 0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #2;
        chk_st("reset", 32'h0, 1'b0, 1'b0);

        // Release between edges; BOOT for one cycle, then sequential fetch.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_st("boot", 32'h0, 1'b0, 1'b0);
        step(); chk_st("run0", 32'h0, 1'b1, 1'b0);
        step(); chk_st("run4", 32'h4, 1'b1, 1'b0);
        step(); chk_st("run8", 32'h8, 1'b1, 1'b0);

        // Jump from 0x8 to 0x100.
        jump = 1; jump_addr = 26'h40;
        step(); idle();
        chk("jmp100", pc, 32'h100);
        chk("plus4_104", pc_plus4, 32'h104);

        // Backward branch by one word: 0x104 - 8 = 0xFC.
        branch_taken = 1; branch_offset = 32'hFFFF_FFFE;
        step(); idle();
        chk("br_back", pc, 32'h0FC);

        // Branch and jump together: jump wins -> 0x100.
        branch_taken = 1; branch_offset = 32'hFFFF_FFFE;
        jump = 1; jump_addr = 26'h40;
        step(); idle();
        chk("jmp_wins", pc, 32'h100);

        // Branch to the top word: 0x104 + 0xFFFFFEF8 = 0xFFFFFFFC.
        branch_taken = 1; branch_offset = 32'hFFFF_FFBE;
        step(); idle();
        chk("br_top", pc, 32'hFFFF_FFFC);
        chk("plus4_wrap", pc_plus4, 32'h0);
        step();
        chk("seq_wrap", pc, 32'h0);

        // Jump to 0x20, then stall two cycles.
        jump = 1; jump_addr = 26'h8;
        step(); idle();
        chk("jmp20", pc, 32'h20);
        stall = 1;
        step(); chk_st("stall1", 32'h20, 1'b1, 1'b0);
        step(); chk_st("stall2", 32'h20, 1'b1, 1'b0);
        stall = 0;
        step(); chk("unstall", pc, 32'h24);

        // Jump to 0x40, then halt with jump asserted: halt wins.
        jump = 1; jump_addr = 26'h10;
        step(); idle();
        chk("jmp40", pc, 32'h40);
        halt = 1; jump = 1; jump_addr = 26'h0; resume = 1;
        step(); idle();
        chk_st("halt", 32'h40, 1'b0, 1'b1);
        halt = 1; resume = 1;
        step(); idle();
        chk_st("halt_resume", 32'h40, 1'b0, 1'b1);
        step();
        chk_st("halt_idle", 32'h40, 1'b0, 1'b1);
        resume = 1;
        step(); idle();
        chk_st("resumed", 32'h40, 1'b1, 1'b0);
        step();
        chk_st("after_resume", 32'h44, 1'b1, 1'b0);

        // Halt again, then reset asynchronously while halted.
        halt = 1;
        step(); idle();
        chk_st("halt2", 32'h44, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_st("async_rst", 32'h0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        chk_st("boot2", 32'h0, 1'b0, 1'b0);
        step(); chk_st("boot2_run", 32'h0, 1'b1, 1'b0);
        step(); chk_st("boot2_seq", 32'h4, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the bench can never hang.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
